// File: rtl/act_unit_arbiter.sv
// Round-robin scheduler that shares one activation unit between NUM_REQ lanes.
// Issued lane indices are queued in order so each result is routed back to its issuer.
module act_unit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_relu,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [DATA_WIDTH-1:0]             au_in_data,
  output logic                              au_in_valid,
  input  logic                              au_in_ready,
  output logic                              au_use_relu,
  input  logic [DATA_WIDTH-1:0]             au_out_data,
  input  logic                              au_out_valid,
  output logic                              au_out_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]    outstanding,
  output logic                              err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  function automatic logic [IDX_W-1:0] next_lane(input logic [IDX_W-1:0] l);
    if (int'(l) == NUM_REQ - 1) return '0;
    return l + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (int'(p) == TAG_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] locked_sel_q, locked_sel_d;
  logic [IDX_W-1:0] tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0] tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] scan_sel;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue_vld;
  logic             push;
  logic             pop;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];

  // Scan downward so the lane closest to rr_ptr (lowest offset) is the last, winning write.
  always_comb begin
    scan_sel = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        scan_sel = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    sel = lock_q ? locked_sel_q : scan_sel;
  end

  always_comb begin
    issue_vld   = rst_n && req_valid[sel] && !fifo_full;
    push        = issue_vld && au_in_ready;
    au_in_valid = issue_vld;
    au_in_data  = '0;
    au_use_relu = 1'b0;
    if (issue_vld) begin
      au_in_data  = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      au_use_relu = req_relu[sel];
    end
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = push && (sel == IDX_W'(i));
    end
  end

  // Results are only routed when a tag is waiting; a stray result is flagged instead.
  always_comb begin
    rsp_data     = au_out_data;
    au_out_ready = !fifo_empty && rsp_ready[head];
    pop          = au_out_valid && au_out_ready;
    rsp_valid    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = au_out_valid && !fifo_empty && (head == IDX_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_sel_d = locked_sel_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q || (au_out_valid && fifo_empty);

    if (push) begin
      tag_mem_d[wr_ptr_q] = sel;
      wr_ptr_d            = next_ptr(wr_ptr_q);
      rr_ptr_d            = next_lane(sel);
      lock_d              = 1'b0;
    end else if (issue_vld) begin
      lock_d       = 1'b1;
      locked_sel_d = sel;
    end

    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_sel_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_sel_q <= locked_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
      tag_mem_q    <= tag_mem_d;
    end
  end

  assign outstanding = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_act_unit_arbiter.sv
// Randomized scoreboard bench for act_unit_arbiter with a behavioural activation-unit stub.
module tb_act_unit_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TD = 4;
  localparam int CW = $clog2(TD + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_relu;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     rsp_data;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     au_in_data;
  logic              au_in_valid;
  logic              au_in_ready;
  logic              au_use_relu;
  logic [DW-1:0]     au_out_data;
  logic              au_out_valid;
  logic              au_out_ready;
  logic [CW-1:0]     outstanding;
  logic              err;

  always #5 clk = ~clk;

  act_unit_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data(req_data), .req_valid(req_valid), .req_relu(req_relu), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .au_in_data(au_in_data), .au_in_valid(au_in_valid), .au_in_ready(au_in_ready),
    .au_use_relu(au_use_relu), .au_out_data(au_out_data), .au_out_valid(au_out_valid),
    .au_out_ready(au_out_ready), .outstanding(outstanding), .err(err)
  );

  typedef struct { int lane; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [DW-1:0] data; int due; } au_t;

  exp_t          sb[$];
  au_t           stub_q[$];
  int            m_tags[$];
  int            m_rr;
  bit            m_lock;
  int            m_locked;
  bit            m_err;
  bit            lane_v[N];
  logic [DW-1:0] lane_d[N];
  bit            lane_r[N];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            inject = 0;
  bit            gen_on = 0;
  int            p_new = 0, p_inrdy = 100, p_rsprdy = 100, max_lat = 1;

  // Q8.8 activation used by the stub unit and by the expected-result side.
  function automatic logic [DW-1:0] act_ref(logic [DW-1:0] x, bit relu);
    int v;
    v = $signed(x);
    if (relu) return (v < 0) ? '0 : x;
    if (v <= -768) return '0;
    if (v >= 768) return x;
    return DW'((v * (v + 768)) / (6 * 256));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_sel();
    if (m_lock) return m_locked;
    for (int k = 0; k < N; k++) begin
      if (lane_v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_lane();
    for (int i = 0; i < N; i++) if (lane_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_lane(int i, logic [DW-1:0] d, bit r);
    lane_v[i] = 1'b1; lane_d[i] = d; lane_r[i] = r;
  endtask

  task automatic clear_model();
    m_tags.delete(); sb.delete(); stub_q.delete();
    m_rr = 0; m_lock = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (gen_on && !lane_v[i] && $urandom_range(99) < p_new)
        set_lane(i, DW'($urandom()), ($urandom_range(1) == 1));
      req_valid[i]          = lane_v[i];
      req_data[i*DW +: DW]  = lane_d[i];
      req_relu[i]           = lane_r[i];
      rsp_ready[i]          = ($urandom_range(99) < p_rsprdy);
    end
    au_in_ready = ($urandom_range(99) < p_inrdy);
    if (stub_q.size() > 0 && stub_q[0].due <= cyc) begin
      au_out_valid = 1'b1;
      au_out_data  = stub_q[0].data;
    end else begin
      au_out_valid = inject;
      au_out_data  = DW'($urandom());
    end
  endtask

  task automatic evaluate();
    int sel, head;
    bit exp_iv, exp_ordy;
    logic [N-1:0] exp_rr, exp_rv;
    logic [DW-1:0] exp_d;
    bit exp_relu;
    sel    = model_sel();
    exp_iv = (sel >= 0) && lane_v[sel] && (m_tags.size() < TD);
    exp_rr = '0; exp_d = '0; exp_relu = 1'b0;
    if (exp_iv) begin
      exp_d = lane_d[sel]; exp_relu = lane_r[sel];
      if (au_in_ready) exp_rr[sel] = 1'b1;
    end
    head     = (m_tags.size() > 0) ? m_tags[0] : -1;
    exp_rv   = '0;
    exp_ordy = (head >= 0) && rsp_ready[head];
    if (au_out_valid && head >= 0) exp_rv[head] = 1'b1;

    check("req_ready", req_ready, exp_rr);
    check("au_in_valid", au_in_valid, exp_iv);
    check("au_in_data", au_in_data, exp_d);
    check("au_use_relu", au_use_relu, exp_relu);
    check("rsp_valid", rsp_valid, exp_rv);
    check("au_out_ready", au_out_ready, exp_ordy);
    check("rsp_data_bcast", rsp_data, au_out_data);
    check("outstanding", outstanding, m_tags.size());
    check("err", err, m_err);

    // Stub activation unit reacts to what the DUT actually presented.
    if (au_in_valid && au_in_ready)
      stub_q.push_back('{data: act_ref(au_in_data, au_use_relu),
                         due: cyc + int'($urandom_range(max_lat, 1))});
    if (au_out_valid && au_out_ready && !inject && stub_q.size() > 0)
      void'(stub_q.pop_front());

    if (exp_iv && au_in_ready) begin
      m_tags.push_back(sel);
      sb.push_back('{lane: sel, data: act_ref(lane_d[sel], lane_r[sel])});
      m_rr = (sel + 1) % N; m_lock = 0; lane_v[sel] = 0;
    end else if (exp_iv) begin
      m_lock = 1; m_locked = sel;
    end
    if (au_out_valid && exp_ordy) void'(m_tags.pop_front());
    if (au_out_valid && head < 0) m_err = 1;
  endtask

  task automatic run_cycle();
    drive();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_au_in_valid"}, au_in_valid, 0);
    check({tag, "_au_out_ready"}, au_out_ready, 0);
    check({tag, "_outstanding"}, outstanding, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic release_reset();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a lane takes a result.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_unexpected: got lane %0d expected no response (cycle %0d)", i, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_lane", i, e.lane);
            check("rsp_value", rsp_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_relu = '0; rsp_ready = '0;
    au_in_ready = 1'b0; au_out_valid = 1'b0; au_out_data = '0;
    for (int i = 0; i < N; i++) begin lane_v[i] = 0; lane_d[i] = '0; lane_r[i] = 0; end
    clear_model();
    #1;
    check_idle("reset");
    release_reset();

    // Four lanes at once: grants must rotate 0,1,2,3.
    set_lane(0, 16'hFF00, 1); set_lane(1, 16'h0010, 1);
    set_lane(2, 16'h0020, 1); set_lane(3, 16'h0030, 1);
    repeat (8) run_cycle();
    set_lane(1, 16'h0180, 1);
    repeat (4) run_cycle();
    set_lane(2, 16'h0300, 0);
    repeat (4) run_cycle();

    // Results held back: the tag FIFO fills and issue stops.
    gen_on = 1; p_new = 100; p_rsprdy = 0;
    repeat (12) run_cycle();
    check("full_outstanding", outstanding, TD);
    check("full_no_issue", au_in_valid, 0);

    // Random traffic with backpressure on both sides.
    p_new = 40; p_inrdy = 65; p_rsprdy = 70; max_lat = 3;
    repeat (1500) run_cycle();
    gen_on = 0; p_inrdy = 100; p_rsprdy = 100;
    n = 0;
    while ((m_tags.size() > 0 || stub_q.size() > 0 || any_lane()) && n < 100) begin
      run_cycle(); n++;
    end
    check("drain_sb_empty", sb.size(), 0);

    // Reset with results in flight.
    gen_on = 1; p_new = 100; p_inrdy = 100; p_rsprdy = 0; max_lat = 1;
    n = 0;
    while (m_tags.size() < 2 && n < 50) begin run_cycle(); n++; end
    check("midrst_outstanding", outstanding, 2'd2 <= outstanding ? outstanding : 3'd2);
    gen_on = 0;
    if (!lane_v[0]) set_lane(0, 16'h0042, 1);
    drive();
    #1 rst_n = 1'b0;
    #1 check_idle("midrst");
    release_reset();
    p_inrdy = 100; p_rsprdy = 100;
    drive();
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);
    evaluate();
    @(posedge clk); #1; cyc++;

    // Stray result with nothing outstanding sets the sticky error.
    n = 0;
    while ((m_tags.size() > 0 || stub_q.size() > 0 || any_lane()) && n < 100) begin
      run_cycle(); n++;
    end
    run_cycle();
    inject = 1;
    run_cycle();
    inject = 0;
    repeat (5) run_cycle();
    check("err_sticky", err, 1);
    #1 rst_n = 1'b0;
    #1 check_idle("err_rst");
    release_reset();
    repeat (3) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
